branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised branch resolution unit for the pipelined MIPS-Lite CPU. It evaluates all conditional branch types (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ), computes the branch target and fall-through address, registers the outcome one cycle after issue, and flags mispredicts for the fetch-redirect logic. It optionally holds a direct-mapped 2-bit saturating branch history table (BHT) that fetch looks up and resolution trains.

## Interface
- XLEN, 32: operand width in bits.
- PC_W, 32: program counter width in bits.
- BHT_DEPTH, 16: BHT entries; power of two, ≥2; IDX_W = log2(BHT_DEPTH).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- lu_pc  input  PC_W  fetch-stage PC for prediction lookup.
- lu_taken  output  1  combinational prediction for lu_pc.
- in_valid  input  1  branch-stage operands valid this cycle.
- flush  input  1  kill the branch-stage instruction this cycle.
- op  input  6  opcode field.
- rt_sel  input  5  rt field; selects BLTZ/BGEZ under REGIMM.
- rn1, rn2  input  XLEN  rs and rt register values (already forwarded).
- pc  input  PC_W  PC of the branch instruction itself.
- imm  input  16  branch offset in words.
- pred_taken  input  1  prediction carried down the pipe with this branch.
- out_valid  output  1  resolved branch result valid.
- taken  output  1  branch condition true.
- target  output  PC_W  pc + 4 + (sign_extend(imm) << 2).
- redirect_pc  output  PC_W  taken ? target : pc + 4.
- mispredict  output  1  taken != pred_taken, qualified by out_valid.

## Operation
- Decode: OP 4 BEQ (rn1 == rn2); OP 5 BNE (rn1 != rn2); OP 6 BLEZ (signed rn1 ≤ 0); OP 7 BGTZ (signed rn1 > 0); OP 1 with rt_sel 0 BLTZ (rn1[XLEN-1]); OP 1 with rt_sel 1 BGEZ (!rn1[XLEN-1]). Every other op/rt combination is a non-branch.
- Issue accepted when in_valid && !flush && op is a branch. Non-branch or flushed issue: out_valid = 0 next cycle, no BHT update.
- Arithmetic: equality on full XLEN; BLEZ/BGTZ/BLTZ/BGEZ are signed two's complement. Target and pc + 4 wrap modulo 2^PC_W; no overflow flag.
- BHT index = pc[IDX_W+1:2] (resolution) and lu_pc[IDX_W+1:2] (lookup). Entry is a 2-bit counter: taken increments saturating at 3, not-taken decrements saturating at 0; lu_taken = counter[1].
- Training occurs on the same edge that registers the accepted result.

## Timing
- Resolution latency 1 cycle: accepted at edge N, outputs valid from edge N until edge N+1. Outputs are registered; one branch per cycle, fully pipelined, no backpressure.
- Registered outputs hold their last values when out_valid = 0; mispredict is forced to 0 when out_valid = 0.
- lu_taken is combinational from the table state; no added latency.
- Simultaneous lookup and update to the same index: lookup returns the pre-update value (read-before-write).
- Back-to-back branches to the same index: the second sees the first's update (counter state after edge N).
- Reset: out_valid, taken, mispredict = 0; target, redirect_pc = 0; all BHT counters = 2'b01 (weakly not-taken). Reset asserted mid-stream discards the in-flight result; in_valid during rst is ignored.
- flush with in_valid in the same cycle: instruction dropped, no result, no training.

## Configuration
- BRU_BHT_EN defined: BHT instantiated as above.
- BRU_BHT_EN undefined: no table storage; lu_taken is tied to 0 (static not-taken); mispredict = taken && out_valid; pred_taken is ignored; all other behaviour is identical.

## Test plan
- Reset, then BEQ with rn1 = rn2 = 0x1234, pc = 0x100, imm = 0xFFFE, pred_taken = 0 -> next cycle out_valid = 1, taken = 1, target = redirect_pc = 0x0FC, mispredict = 1.
- BLEZ with rn1 = 0x80000000 -> taken = 1; BGTZ with rn1 = 0 -> taken = 0, redirect_pc = pc + 4; BGEZ (OP 1, rt_sel 1) with rn1 = 0 -> taken = 1.
- BHT_EN: three taken branches at pc = 0x40 -> lu_pc = 0x40 reads 0 after reset, 1 after the first update, and stays 1 (counter saturates at 3); four not-taken branches return lu_taken to 0.
- Same-index lookup on the same cycle as an update from 01 to 10 -> lu_taken = 0 that cycle, 1 the next.
- flush with a valid BNE, and a separate issue with op = 0x23 -> out_valid = 0, BHT unchanged.
- Target wrap: pc = 0xFFFFFFFC, imm = 0x0001 -> target = 0x00000004. Assert rst during a valid result -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates MIPS-Lite conditional branches and registers the outcome one cycle after issue.
// Define BRU_BHT_EN to add a direct-mapped 2-bit saturating branch history table for fetch prediction.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,   // must be >= 18 so the shifted offset fits
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lu_pc,
    output logic            lu_taken,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [5:0]      op,
    input  logic [4:0]      rt_sel,
    input  logic [XLEN-1:0] rn1,
    input  logic [XLEN-1:0] rn2,
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     imm,
    input  logic            pred_taken,
    output logic            out_valid,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic [PC_W-1:0] redirect_pc,
    output logic            mispredict
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [5:0] {
        OP_REGIMM = 6'd1,
        OP_BEQ    = 6'd4,
        OP_BNE    = 6'd5,
        OP_BLEZ   = 6'd6,
        OP_BGTZ   = 6'd7
    } br_op_e;

    logic            w_is_branch;
    logic            w_cond;
    logic            w_accept;
    logic            w_rn1_neg;
    logic            w_rn1_zero;
    logic            w_pred_miss;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_target;

    logic            r_valid;
    logic            r_taken;
    logic            r_mispredict;
    logic [PC_W-1:0] r_target;
    logic [PC_W-1:0] r_redirect;

    assign w_rn1_neg  = rn1[XLEN-1];
    assign w_rn1_zero = (rn1 == '0);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_is_branch = 1'b0;
        w_cond      = 1'b0;
        case (op)
            OP_BEQ: begin
                w_is_branch = 1'b1;
                w_cond      = (rn1 == rn2);
            end
            OP_BNE: begin
                w_is_branch = 1'b1;
                w_cond      = (rn1 != rn2);
            end
            OP_BLEZ: begin
                w_is_branch = 1'b1;
                w_cond      = w_rn1_neg | w_rn1_zero;
            end
            OP_BGTZ: begin
                w_is_branch = 1'b1;
                w_cond      = !w_rn1_neg && !w_rn1_zero;
            end
            OP_REGIMM: begin
                if (rt_sel == 5'd0) begin
                    w_is_branch = 1'b1;
                    w_cond      = w_rn1_neg;
                end else if (rt_sel == 5'd1) begin
                    w_is_branch = 1'b1;
                    w_cond      = !w_rn1_neg;
                end
            end
            default: begin
                w_is_branch = 1'b0;
                w_cond      = 1'b0;
            end
        endcase
    end

    assign w_accept   = in_valid && !flush && w_is_branch;
    // Word offset, sign-extended and scaled to bytes; additions wrap modulo 2^PC_W.
    assign w_offset   = {{(PC_W-18){imm[15]}}, imm, 2'b00};
    assign w_pc_plus4 = pc + PC_W'(4);
    assign w_target   = w_pc_plus4 + w_offset;

`ifdef BRU_BHT_EN
    logic [1:0]       r_bht [BHT_DEPTH];
    logic [IDX_W-1:0] w_lu_idx;
    logic [IDX_W-1:0] w_up_idx;
    logic             w_unused;

    assign w_lu_idx    = lu_pc[IDX_W+1:2];
    assign w_up_idx    = pc[IDX_W+1:2];
    // Reads the pre-edge table, so a same-cycle update to this index is not yet visible.
    assign lu_taken    = r_bht[w_lu_idx][1];
    assign w_pred_miss = w_cond != pred_taken;
    assign w_unused    = ^lu_pc;

    // NOTE: the table is reset entry by entry because prediction must start from a known weakly-not-taken state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept) begin
            if (w_cond) begin
                if (r_bht[w_up_idx] != 2'b11) r_bht[w_up_idx] <= r_bht[w_up_idx] + 2'd1;
            end else begin
                if (r_bht[w_up_idx] != 2'b00) r_bht[w_up_idx] <= r_bht[w_up_idx] - 2'd1;
            end
        end
    end
`else
    logic w_unused;

    assign lu_taken    = 1'b0;
    assign w_pred_miss = w_cond;
    assign w_unused    = ^{lu_pc, pred_taken};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_target     <= '0;
            r_redirect   <= '0;
        end else begin
            r_valid      <= w_accept;
            r_mispredict <= w_accept && w_pred_miss;
            if (w_accept) begin
                r_taken    <= w_cond;
                r_target   <= w_target;
                r_redirect <= w_cond ? w_target : w_pc_plus4;
            end
        end
    end

    assign out_valid   = r_valid;
    assign taken       = r_taken;
    assign mispredict  = r_mispredict;
    assign target      = r_target;
    assign redirect_pc = r_redirect;

endmodule
